// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide engine: op codes, FSM states, sizes.
package mips_pkg;

    localparam int unsigned MD_W       = 32;
    localparam int unsigned MD_ITER    = 32;
    localparam int unsigned MD_LATENCY = 34;

    // Matches funct[1:0] of MULT/MULTU/DIV/DIVU (0x18-0x1B)
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    // Two's-complement magnitude; 0x80000000 stays 0x80000000 as an unsigned value
    function automatic logic [MD_W-1:0] md_abs(input logic [MD_W-1:0] v, input logic is_signed);
        return (is_signed && v[MD_W-1]) ? (~v + MD_W'(1)) : v;
    endfunction

    function automatic logic [MD_W-1:0] md_neg32(input logic [MD_W-1:0] v);
        return ~v + MD_W'(1);
    endfunction

    function automatic logic [2*MD_W-1:0] md_neg64(input logic [2*MD_W-1:0] v);
        return ~v + (2*MD_W)'(1);
    endfunction

endpackage

// File: rtl/md_datapath.sv
// Combinational per-iteration step (shift-add / restoring trial-subtract) and final sign fixup.
module md_datapath
    import mips_pkg::*;
(
    input  logic                is_div_i,
    input  logic [2*MD_W-1:0]   acc_i,
    input  logic [MD_W-1:0]     a_mag_i,
    input  logic [MD_W-1:0]     b_mag_i,
    input  logic                sign_a_i,
    input  logic                sign_b_i,
    output logic [2*MD_W-1:0]   step_o,
    output logic [2*MD_W-1:0]   fix_o
);

    logic [MD_W:0]       mul_sum;
    logic [2*MD_W-1:0]   mul_next;
    logic                div_ge;
    logic [MD_W-1:0]     div_rem;
    logic [2*MD_W-1:0]   div_next;
    logic                res_neg;
    logic [MD_W-1:0]     quot_fix;
    logic [MD_W-1:0]     rem_fix;
    logic [MD_W-1:0]     dividend_raw;
    logic [2*MD_W-1:0]   mul_fix;
    logic [2*MD_W-1:0]   div_fix;

    // One iteration: multiply adds multiplicand into the upper half then shifts right;
    // divide shifts {rem,quot} left and keeps the trial subtraction when it does not underflow
    always_comb begin
        mul_sum  = {1'b0, acc_i[2*MD_W-1:MD_W]} + (acc_i[0] ? {1'b0, a_mag_i} : (MD_W+1)'(0));
        mul_next = {mul_sum, acc_i[MD_W-1:1]};

        div_ge   = (acc_i[2*MD_W-1:MD_W-1] >= {1'b0, b_mag_i});
        div_rem  = acc_i[2*MD_W-2:MD_W-1] - b_mag_i;
        div_next = div_ge ? {div_rem, acc_i[MD_W-2:0], 1'b1}
                          : {acc_i[2*MD_W-2:0], 1'b0};

        step_o   = is_div_i ? div_next : mul_next;
    end

    // Sign correction and packing; divide-by-zero returns the dividend as supplied with all-ones quotient
    always_comb begin
        res_neg      = sign_a_i ^ sign_b_i;
        mul_fix      = res_neg ? md_neg64(acc_i) : acc_i;
        quot_fix     = res_neg ? md_neg32(acc_i[MD_W-1:0]) : acc_i[MD_W-1:0];
        rem_fix      = sign_a_i ? md_neg32(acc_i[2*MD_W-1:MD_W]) : acc_i[2*MD_W-1:MD_W];
        dividend_raw = sign_a_i ? md_neg32(a_mag_i) : a_mag_i;

        if (b_mag_i == '0) begin
            div_fix = {dividend_raw, {MD_W{1'b1}}};
        end else begin
            div_fix = {rem_fix, quot_fix};
        end

        fix_o = is_div_i ? div_fix : mul_fix;
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine producing {HI,LO} with a one-cycle write strobe.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int unsigned ITER = MD_ITER
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [MD_W-1:0]     rs_data,
    input  logic [MD_W-1:0]     rt_data,
    output logic                busy,
    output logic                done,
    output logic                hi_en,
    output logic                lo_en,
    output logic [2*MD_W-1:0]   result
);

    localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

    md_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*MD_W-1:0]    acc_q, acc_d;
    logic [MD_W-1:0]      a_mag_q, a_mag_d;
    logic [MD_W-1:0]      b_mag_q, b_mag_d;
    logic                 is_div_q, is_div_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic [2*MD_W-1:0]    result_q, result_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 op_signed;
    logic [MD_W-1:0]      rs_mag;
    logic [MD_W-1:0]      rt_mag;
    logic [2*MD_W-1:0]    step;
    logic [2*MD_W-1:0]    fix;

    assign op_signed = ~op[0];
    assign rs_mag    = md_abs(rs_data, op_signed);
    assign rt_mag    = md_abs(rt_data, op_signed);

    md_datapath u_datapath (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .a_mag_i  (a_mag_q),
        .b_mag_i  (b_mag_q),
        .sign_a_i (sign_a_q),
        .sign_b_i (sign_b_q),
        .step_o   (step),
        .fix_o    (fix)
    );

    // Next-state, datapath loads and registered output values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d = op[1];
                    a_mag_d  = rs_mag;
                    b_mag_d  = rt_mag;
                    sign_a_d = op_signed & rs_data[MD_W-1];
                    sign_b_d = op_signed & rt_data[MD_W-1];
                    acc_d    = {{MD_W{1'b0}}, (op[1] ? rs_mag : rt_mag)};
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d = step;
                if (cnt_q == CW'(ITER - 1)) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            FIX: begin
                result_d = fix;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    // State and datapath registers; reset aborts any operation without a done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign hi_en  = done_q;
    assign lo_en  = done_q;
    assign result = result_q;

endmodule
